fdc_sector_server: RTL and testbench

- Disk-side responder for the nec765 sector request/acknowledge interface: decodes the request word on disk_sr, services one sector read or write against a byte-addressed disk-image memory, and reports completion on disk_cr.
- Read data is streamed into the FDC input FIFO with one strobe per byte; write data is drained from the FDC output FIFO with one strobe per byte.
- Sits between nec765 and the SD/SDRAM image store arbiter. Replaces firmware servicing of disk_sr.

---
 rtl/fdc_pkg.sv | 30 +++
 rtl/fdc_chs_to_addr.sv | 39 +++
 rtl/fdc_sector_server.sv | 178 +++++++++++++++++
 tb/tb_fdc_sector_server.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdc_pkg.sv
// Shared definitions for the nec765 sector request/acknowledge interface.
// The nec765 side can import the same bit indices so both ends agree on the layout.
package fdc_pkg;

  // disk_sr field positions (FDC -> server)
  localparam int SR_SID_LSB = 0;
  localparam int SR_CYL_LSB = 8;
  localparam int SR_HEAD    = 15;
  localparam int SR_ACK     = 16;
  localparam int SR_RDA     = 17;
  localparam int SR_RDB     = 18;
  localparam int SR_WRA     = 20;
  localparam int SR_WRB     = 21;

  // disk_cr flag positions (server -> FDC)
  localparam int CR_DONE     = 4;
  localparam int CR_NOTFOUND = 3;
  localparam int CR_WP       = 2;

  // Sector server state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_DECODE  = 3'd1;
  localparam state_t ST_RD_REQ  = 3'd2;
  localparam state_t ST_RD_PUSH = 3'd3;
  localparam state_t ST_WR_POP  = 3'd4;
  localparam state_t ST_WR_REQ  = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

endpackage

// File: rtl/fdc_chs_to_addr.sv
// Converts a drive/cylinder/head/sector-ID tuple into the byte address of the
// sector inside the disk-image memory, and flags tuples that do not exist.
module fdc_chs_to_addr #(
  parameter int                SECTOR_BYTES = 512,
  parameter int                SPT          = 9,
  parameter logic [7:0]        FIRST_ID     = 8'hC1,
  parameter int                TRACKS       = 42,
  parameter int                SIDES        = 1,
  parameter int                ADDR_W       = 24,
  parameter logic [ADDR_W-1:0] DRIVE_B_BASE = 'h080000
) (
  input  logic              drive,
  input  logic              loaded,
  input  logic [6:0]        cyl,
  input  logic              head,
  input  logic [7:0]        sid,
  output logic [ADDR_W-1:0] addr,
  output logic              not_found
);

  logic [31:0] base_w;
  logic [31:0] sector_idx;
  logic [31:0] offset;

  // Linear sector index scaled to bytes on top of the drive base; range check in parallel
  always_comb begin
    base_w     = drive ? 32'(DRIVE_B_BASE) : 32'd0;
    sector_idx = (32'(cyl) * 32'(SIDES) + 32'(head)) * 32'(SPT)
               + (32'(sid) - 32'(FIRST_ID));
    offset     = sector_idx * 32'(SECTOR_BYTES);
    addr       = ADDR_W'(base_w + offset);
    not_found  = !loaded
              || (32'(cyl) >= 32'(TRACKS))
              || (32'(head) >= 32'(SIDES))
              || (sid < FIRST_ID)
              || (32'(sid) >= 32'(FIRST_ID) + 32'(SPT));
  end

endmodule

// File: rtl/fdc_sector_server.sv
// Disk-side responder for the nec765: services one sector read or write per
// request against a byte-addressed image memory and reports completion on disk_cr.
module fdc_sector_server
  import fdc_pkg::*;
#(
  parameter int                SECTOR_BYTES = 512,
  parameter int                SPT          = 9,
  parameter logic [7:0]        FIRST_ID     = 8'hC1,
  parameter int                TRACKS       = 42,
  parameter int                SIDES        = 1,
  parameter int                ADDR_W       = 24,
  parameter logic [ADDR_W-1:0] DRIVE_B_BASE = 'h080000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       disk_sr,
  output logic [31:0]       disk_cr,
  output logic [7:0]        fdc_rd_data,
  output logic              fdc_rd_strobe,
  input  logic [7:0]        fdc_wr_data,
  output logic              fdc_wr_strobe,
  input  logic [1:0]        drive_loaded,
  input  logic [1:0]        disk_wp,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  localparam int               CNT_W = $clog2(SECTOR_BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SECTOR_BYTES - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t            state;
  logic [7:0]        sid;
  logic [6:0]        cyl;
  logic              head;
  logic              drive;
  logic              dir_wr;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] base;
  logic              nf_q;
  logic              wp_q;
  logic [7:0]        rd_data_q;
  logic [7:0]        wr_data_q;

  logic              any_req;
  logic              calc_nf;
  logic [ADDR_W-1:0] calc_addr;
  logic              wp_hit;
  logic              unused_sr;

  assign any_req = disk_sr[SR_RDA] | disk_sr[SR_RDB] | disk_sr[SR_WRA] | disk_sr[SR_WRB];
  assign wp_hit  = dir_wr & disk_wp[drive];

  // The ack-of-ack bit and the spare request bits play no part in sequencing
  assign unused_sr = ^{disk_sr[31:22], disk_sr[19], disk_sr[SR_ACK]};

  fdc_chs_to_addr #(
    .SECTOR_BYTES (SECTOR_BYTES),
    .SPT          (SPT),
    .FIRST_ID     (FIRST_ID),
    .TRACKS       (TRACKS),
    .SIDES        (SIDES),
    .ADDR_W       (ADDR_W),
    .DRIVE_B_BASE (DRIVE_B_BASE)
  ) u_chs (
    .drive     (drive),
    .loaded    (drive_loaded[drive]),
    .cyl       (cyl),
    .head      (head),
    .sid       (sid),
    .addr      (calc_addr),
    .not_found (calc_nf)
  );

  // Request sequencer: latch the request, decode it, then move one byte per memory handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sid       <= '0;
      cyl       <= '0;
      head      <= 1'b0;
      drive     <= 1'b0;
      dir_wr    <= 1'b0;
      cnt       <= '0;
      base      <= '0;
      nf_q      <= 1'b0;
      wp_q      <= 1'b0;
      rd_data_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            sid  <= disk_sr[SR_SID_LSB +: 8];
            cyl  <= disk_sr[SR_CYL_LSB +: 7];
            head <= disk_sr[SR_HEAD];
            if (disk_sr[SR_RDA]) begin
              drive  <= 1'b0;
              dir_wr <= 1'b0;
            end else if (disk_sr[SR_RDB]) begin
              drive  <= 1'b1;
              dir_wr <= 1'b0;
            end else if (disk_sr[SR_WRA]) begin
              drive  <= 1'b0;
              dir_wr <= 1'b1;
            end else begin
              drive  <= 1'b1;
              dir_wr <= 1'b1;
            end
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          nf_q <= calc_nf;
          wp_q <= wp_hit;
          cnt  <= '0;
          base <= calc_addr;
          if (calc_nf || wp_hit) begin
            state <= ST_DONE;
          end else if (dir_wr) begin
            state <= ST_WR_POP;
          end else begin
            state <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (mem_ack) begin
            rd_data_q <= mem_rdata;
            state     <= ST_RD_PUSH;
          end
        end
        ST_RD_PUSH: begin
          cnt   <= cnt + ONE;
          state <= (cnt == LAST) ? ST_DONE : ST_RD_REQ;
        end
        ST_WR_POP: begin
          wr_data_q <= fdc_wr_data;
          state     <= ST_WR_REQ;
        end
        ST_WR_REQ: begin
          if (mem_ack) begin
            cnt   <= cnt + ONE;
            state <= (cnt == LAST) ? ST_DONE : ST_WR_POP;
          end
        end
        ST_DONE: begin
          if (!any_req) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req       = (state == ST_RD_REQ) || (state == ST_WR_REQ);
  assign mem_we        = (state == ST_WR_REQ);
  assign mem_addr      = mem_req ? (base + ADDR_W'(cnt)) : '0;
  assign mem_wdata     = wr_data_q;
  assign fdc_rd_data   = rd_data_q;
  assign fdc_rd_strobe = (state == ST_RD_PUSH);
  assign fdc_wr_strobe = (state == ST_WR_POP);

  // Completion word is only visible while parked in DONE, so leaving DONE clears it
  always_comb begin
    disk_cr = '0;
    if (state == ST_DONE) begin
      disk_cr[CR_DONE]     = 1'b1;
      disk_cr[CR_NOTFOUND] = nf_q;
      disk_cr[CR_WP]       = wp_q;
    end
  end

endmodule

// File: tb/tb_fdc_sector_server.sv
// Scoreboard bench for fdc_sector_server: expected memory accesses and FIFO
// bytes are queued when a request is issued and consumed as the DUT produces them.
module tb_fdc_sector_server;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] disk_sr;
  logic [31:0] disk_cr;
  logic [7:0]  fdc_rd_data;
  logic        fdc_rd_strobe;
  logic [7:0]  fdc_wr_data;
  logic        fdc_wr_strobe;
  logic [1:0]  drive_loaded;
  logic [1:0]  disk_wp;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  int compared   = 0;
  int mismatched = 0;
  int rd_count   = 0;
  int wr_count   = 0;
  int req_cycles = 0;
  int wait_cnt   = 0;
  logic pop_pending = 1'b0;

  logic [24:0] exp_acc[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_wd[$];
  logic [7:0]  fifo[$];

  always #5 clk = ~clk;

  fdc_sector_server dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .disk_sr       (disk_sr),
    .disk_cr       (disk_cr),
    .fdc_rd_data   (fdc_rd_data),
    .fdc_rd_strobe (fdc_rd_strobe),
    .fdc_wr_data   (fdc_wr_data),
    .fdc_wr_strobe (fdc_wr_strobe),
    .drive_loaded  (drive_loaded),
    .disk_wp       (disk_wp),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack)
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  function automatic logic [23:0] exp_base(input logic drv, input int cyl, input int head, input int sid);
    int lin;
    lin = (cyl * 1 + head) * 9 + (sid - 'hC1);
    return 24'((drv ? 'h080000 : 0) + lin * 512);
  endfunction

  function automatic logic [31:0] make_sr(input int bit_n, input logic [6:0] cyl, input logic hd, input logic [7:0] sid);
    return (32'd1 << bit_n) | {16'b0, hd, cyl, sid};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] sr);
    @(negedge clk);
    disk_sr = sr;
  endtask

  task automatic queueRead(input logic [23:0] base);
    for (int i = 0; i < 512; i++) begin
      exp_acc.push_back({1'b0, base + 24'(i)});
      exp_rd.push_back(mem_byte(base + 24'(i)));
    end
  endtask

  task automatic waitDone(input int limit);
    int n;
    n = 0;
    while (!disk_cr[4] && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 64'(disk_cr[4]), 64'd1);
  endtask

  // Memory responder with two-cycle latency, FWFT output FIFO and strobe monitor
  initial begin
    mem_ack     = 1'b0;
    mem_rdata   = 8'h00;
    fdc_wr_data = 8'h00;
    forever begin
      @(negedge clk);
      if (pop_pending) begin
        if (fifo.size() > 0) fifo.delete(0);
        pop_pending = 1'b0;
      end
      if (fdc_wr_strobe) begin
        wr_count++;
        pop_pending = 1'b1;
      end
      if (fdc_rd_strobe) begin
        rd_count++;
        if (exp_rd.size() == 0) checkOutput("rd_unexpected", 64'(exp_rd.size()), 64'd1);
        else checkOutput("rd_byte", 64'(fdc_rd_data), 64'(exp_rd.pop_front()));
      end
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        req_cycles++;
        wait_cnt++;
        if (wait_cnt >= 2) begin
          wait_cnt = 0;
          mem_ack  = 1'b1;
          if (exp_acc.size() == 0) checkOutput("mem_unexpected", 64'(exp_acc.size()), 64'd1);
          else checkOutput("mem_access", 64'({mem_we, mem_addr}), 64'(exp_acc.pop_front()));
          if (mem_we) begin
            if (exp_wd.size() == 0) checkOutput("wdata_unexpected", 64'(exp_wd.size()), 64'd1);
            else checkOutput("mem_wdata", 64'(mem_wdata), 64'(exp_wd.pop_front()));
          end else begin
            mem_rdata = mem_byte(mem_addr);
          end
        end
      end else begin
        wait_cnt = 0;
      end
      fdc_wr_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  // Watchdog so a stuck DUT still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    logic [23:0] base;
    int rd0, wr0, req0, guard;

    rst_n        = 1'b0;
    disk_sr      = '0;
    drive_loaded = 2'b11;
    disk_wp      = 2'b00;
    repeat (3) @(negedge clk);
    checkOutput("reset_cr", 64'(disk_cr), 64'h0);
    checkOutput("reset_ctl", 64'({fdc_rd_strobe, fdc_wr_strobe, mem_req, mem_we}), 64'h0);
    checkOutput("reset_data", 64'({mem_addr, mem_wdata, fdc_rd_data}), 64'h0);
    rst_n = 1'b1;

    // Read A, cyl 2, head 0, sid C3
    base = exp_base(1'b0, 2, 0, 'hC3);
    queueRead(base);
    rd0 = rd_count;
    wr0 = wr_count;
    applyStimulus(make_sr(17, 7'd2, 1'b0, 8'hC3));
    waitDone(4000);
    checkOutput("rdA_cr", 64'(disk_cr), 64'h10);
    checkOutput("rdA_bytes", 64'(rd_count - rd0), 64'd512);
    checkOutput("rdA_no_pops", 64'(wr_count - wr0), 64'd0);
    checkOutput("rdA_rd_left", 64'(exp_rd.size()), 64'd0);
    checkOutput("rdA_acc_left", 64'(exp_acc.size()), 64'd0);
    applyStimulus(32'h0);
    @(negedge clk);
    checkOutput("rdA_cr_clear", 64'(disk_cr), 64'h0);

    // Read B of a sector ID below the first one
    req0 = req_cycles;
    applyStimulus(make_sr(18, 7'd0, 1'b0, 8'hC0));
    repeat (2) @(negedge clk);
    checkOutput("rdB_c0_cr", 64'(disk_cr), 64'h18);
    checkOutput("rdB_c0_noreq", 64'(req_cycles - req0), 64'd0);
    applyStimulus(32'h0);
    @(negedge clk);

    // Write A to a write-protected drive
    disk_wp = 2'b01;
    req0 = req_cycles;
    wr0  = wr_count;
    applyStimulus(make_sr(20, 7'd0, 1'b0, 8'hC1));
    repeat (2) @(negedge clk);
    checkOutput("wrA_wp_cr", 64'(disk_cr), 64'h14);
    checkOutput("wrA_wp_noreq", 64'(req_cycles - req0), 64'd0);
    checkOutput("wrA_wp_nopop", 64'(wr_count - wr0), 64'd0);
    applyStimulus(32'h0);
    @(negedge clk);
    disk_wp = 2'b00;

    // Write B, cyl 0, sid C1, FIFO carries 0..255 twice
    base = exp_base(1'b1, 0, 0, 'hC1);
    for (int i = 0; i < 512; i++) begin
      fifo.push_back(8'(i));
      exp_wd.push_back(8'(i));
      exp_acc.push_back({1'b1, base + 24'(i)});
    end
    rd0 = rd_count;
    wr0 = wr_count;
    applyStimulus(make_sr(21, 7'd0, 1'b0, 8'hC1));
    waitDone(4000);
    checkOutput("wrB_cr", 64'(disk_cr), 64'h10);
    checkOutput("wrB_pops", 64'(wr_count - wr0), 64'd512);
    checkOutput("wrB_no_push", 64'(rd_count - rd0), 64'd0);
    checkOutput("wrB_wd_left", 64'(exp_wd.size()), 64'd0);
    checkOutput("wrB_acc_left", 64'(exp_acc.size()), 64'd0);
    checkOutput("wrB_fifo_left", 64'(fifo.size()), 64'd0);
    applyStimulus(32'h0);
    @(negedge clk);

    // Reset in the middle of a read, then restart from byte 0
    base = exp_base(1'b0, 2, 0, 'hC3);
    queueRead(base);
    rd0 = rd_count;
    applyStimulus(make_sr(17, 7'd2, 1'b0, 8'hC3));
    guard = 0;
    while ((rd_count - rd0) < 100 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rst_reached_100", 64'((rd_count - rd0) >= 100), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_cr", 64'(disk_cr), 64'h0);
    checkOutput("rst_ctl", 64'({fdc_rd_strobe, fdc_wr_strobe, mem_req, mem_we}), 64'h0);
    checkOutput("rst_data", 64'({mem_addr, mem_wdata, fdc_rd_data}), 64'h0);
    rd0 = rd_count;
    disk_sr = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_no_strobes", 64'(rd_count - rd0), 64'd0);
    exp_rd.delete();
    exp_acc.delete();
    rst_n = 1'b1;
    queueRead(base);
    rd0 = rd_count;
    applyStimulus(make_sr(17, 7'd2, 1'b0, 8'hC3));
    waitDone(4000);
    checkOutput("restart_cr", 64'(disk_cr), 64'h10);
    checkOutput("restart_bytes", 64'(rd_count - rd0), 64'd512);
    checkOutput("restart_acc_left", 64'(exp_acc.size()), 64'd0);
    applyStimulus(32'h0);
    @(negedge clk);

    // Read A and write A together: read wins; last sector of cyl 1
    base = exp_base(1'b0, 1, 0, 'hC9);
    queueRead(base);
    rd0 = rd_count;
    wr0 = wr_count;
    applyStimulus(make_sr(17, 7'd1, 1'b0, 8'hC9) | make_sr(20, 7'd1, 1'b0, 8'hC9));
    waitDone(4000);
    checkOutput("prio_cr", 64'(disk_cr), 64'h10);
    checkOutput("prio_bytes", 64'(rd_count - rd0), 64'd512);
    checkOutput("prio_no_pops", 64'(wr_count - wr0), 64'd0);
    checkOutput("prio_acc_left", 64'(exp_acc.size()), 64'd0);
    applyStimulus(32'h0);
    @(negedge clk);

    // Out-of-range cases: cyl 42, sid one past the track, unloaded drive B
    for (int k = 0; k < 3; k++) begin
      logic [31:0] sr;
      if (k == 0) sr = make_sr(17, 7'd42, 1'b0, 8'hC1);
      else if (k == 1) sr = make_sr(17, 7'd0, 1'b0, 8'hCA);
      else sr = make_sr(18, 7'd0, 1'b0, 8'hC1);
      drive_loaded = (k == 2) ? 2'b01 : 2'b11;
      req0 = req_cycles;
      applyStimulus(sr);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("notfound_cr_%0d", k), 64'(disk_cr), 64'h18);
      checkOutput($sformatf("notfound_noreq_%0d", k), 64'(req_cycles - req0), 64'd0);
      applyStimulus(32'h0);
      @(negedge clk);
      checkOutput($sformatf("notfound_clear_%0d", k), 64'(disk_cr), 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
